epwm_edge_delay_shaper: RTL

- Multi-channel ePWM re-timing block. Per channel, each input ePWM edge is delayed by a programmable number of FCB_CLK cycles: rising edges by a rise delay, falling edges by a fall delay.
- Pulses shorter than the applicable delay are swallowed.
- Delay values are double-buffered (shadow/active) and take effect at a period boundary, the next input rising edge.
- Sits between external ePWM inputs and the pad-side ePWM outputs in the pulse-counter/CCB fabric. Replaces hand-wired edge-pulse + counter + SR-FSM chains.

---
 rtl/epwm_edge_delay_shaper.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/epwm_edge_delay_shaper.sv
// Purpose: per-channel ePWM edge re-timing. Rising and falling edges are delayed
//          by programmable FCB_CLK counts, and pulses shorter than the delay are swallowed.
// Latency: an input edge reaches pwm_o D cycles after pwm_q takes it (D=0: on the same edge).
// Backpressure: none. Inputs are sampled every cycle, and a short pulse is absorbed and
//          reported on drop_o.
//
// Ports:
//   FCB_CLK, FCB_RST_N     clock, asynchronous active-low reset
//   en_i[NUM_CH]           per-channel enable (level)
//   pwm_i[NUM_CH]          ePWM inputs, synchronous to FCB_CLK
//   rise_dly_i/fall_dly_i  shadow delay values, channel c at [c*CNT_W +: CNT_W]
//   load_i[NUM_CH]         strobe that captures the delay values into the shadow registers
//   pwm_o                  shaped output; busy_o is high while a delay is counting
//   pend_o                 shadow loaded and not yet active; drop_o pulses for a swallowed pulse
//   drop_cnt_o             saturating per-channel drop count, 8 bits per channel
//                          (only when EPWM_SHAPER_STAT_EN is defined)
module epwm_edge_delay_shaper #(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 16,
  parameter int unsigned RISE_INIT = 0,
  parameter int unsigned FALL_INIT = 0
) (
  input  logic                    FCB_CLK,
  input  logic                    FCB_RST_N,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       pwm_i,
  input  logic [NUM_CH*CNT_W-1:0] rise_dly_i,
  input  logic [NUM_CH*CNT_W-1:0] fall_dly_i,
  input  logic [NUM_CH-1:0]       load_i,
  output logic [NUM_CH-1:0]       pwm_o,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       pend_o,
  output logic [NUM_CH-1:0]       drop_o
`ifdef EPWM_SHAPER_STAT_EN
  ,output logic [NUM_CH*8-1:0]    drop_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE_LO, DLY_RISE, HIGH, DLY_FALL} state_t;

  localparam logic [CNT_W-1:0] RISE_RST = CNT_W'(RISE_INIT);
  localparam logic [CNT_W-1:0] FALL_RST = CNT_W'(FALL_INIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // The startup blanking chain. No edge is acted on until r_rdy[1] is set.
  logic [1:0] r_rdy;

  always_ff @(posedge FCB_CLK or negedge FCB_RST_N) begin
    if (!FCB_RST_N) r_rdy <= 2'b00;
    else            r_rdy <= {r_rdy[0], 1'b1};
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_rise_act, r_fall_act, r_rise_shd, r_fall_shd;
    logic [CNT_W-1:0] w_rise_eff;
    logic             r_pwm_q, r_pwm_o, r_drop, r_pend;
    logic             w_rise, w_fall, w_drop, w_copy;

    assign w_rise = r_rdy[1] &  pwm_i[c] & ~r_pwm_q;
    assign w_fall = r_rdy[1] & ~pwm_i[c] &  r_pwm_q;

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_drop      = 1'b0;
      w_copy      = 1'b0;
      w_rise_eff  = r_rise_act;
      if (!en_i[c]) begin
        w_state_nxt = IDLE_LO;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          IDLE_LO: if (w_rise) begin
            // A load that coincides with this rise applies from the next period, so
            // skip the copy and leave pend set.
            if (r_pend && !load_i[c]) begin
              w_copy     = 1'b1;
              w_rise_eff = r_rise_shd;
            end
            if (w_rise_eff == '0) begin
              w_state_nxt = HIGH;
            end else begin
              w_state_nxt = DLY_RISE;
              w_cnt_nxt   = w_rise_eff - CNT_ONE;
            end
          end
          DLY_RISE: begin
            // An edge takes priority over expiry of the count.
            if (w_fall) begin
              w_state_nxt = IDLE_LO;
              w_cnt_nxt   = '0;
              w_drop      = 1'b1;
            end else if (r_cnt == '0) begin
              w_state_nxt = HIGH;
            end else begin
              w_cnt_nxt = r_cnt - CNT_ONE;
            end
          end
          HIGH: if (w_fall) begin
            if (r_fall_act == '0) begin
              w_state_nxt = IDLE_LO;
            end else begin
              w_state_nxt = DLY_FALL;
              w_cnt_nxt   = r_fall_act - CNT_ONE;
            end
          end
          DLY_FALL: begin
            if (w_rise) begin
              // The low gap is swallowed. This is not a new period, so no shadow copy.
              w_state_nxt = HIGH;
              w_cnt_nxt   = '0;
              w_drop      = 1'b1;
            end else if (r_cnt == '0) begin
              w_state_nxt = IDLE_LO;
            end else begin
              w_cnt_nxt = r_cnt - CNT_ONE;
            end
          end
          default: begin
            w_state_nxt = IDLE_LO;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge FCB_CLK or negedge FCB_RST_N) begin
      if (!FCB_RST_N) begin
        r_state    <= IDLE_LO;
        r_cnt      <= '0;
        r_pwm_q    <= 1'b0;
        r_pwm_o    <= 1'b0;
        r_drop     <= 1'b0;
        r_pend     <= 1'b0;
        r_rise_act <= RISE_RST;
        r_fall_act <= FALL_RST;
        r_rise_shd <= RISE_RST;
        r_fall_shd <= FALL_RST;
      end else begin
        r_pwm_q <= pwm_i[c];
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_drop  <= w_drop;
        r_pwm_o <= (w_state_nxt == HIGH) || (w_state_nxt == DLY_FALL);
        if (w_copy) begin
          r_rise_act <= r_rise_shd;
          r_fall_act <= r_fall_shd;
        end
        if (load_i[c]) begin
          r_rise_shd <= rise_dly_i[c*CNT_W +: CNT_W];
          r_fall_shd <= fall_dly_i[c*CNT_W +: CNT_W];
          r_pend     <= 1'b1;
        end else if (w_copy) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign pwm_o[c]  = r_pwm_o;
    assign busy_o[c] = (r_state == DLY_RISE) || (r_state == DLY_FALL);
    assign pend_o[c] = r_pend;
    assign drop_o[c] = r_drop;

`ifdef EPWM_SHAPER_STAT_EN
    // The count updates on the same edge that raises drop_o. It holds at 255.
    logic [7:0] r_drop_cnt;
    always_ff @(posedge FCB_CLK or negedge FCB_RST_N) begin
      if (!FCB_RST_N)                          r_drop_cnt <= 8'd0;
      else if (w_drop && r_drop_cnt != 8'hFF)  r_drop_cnt <= r_drop_cnt + 8'd1;
    end
    assign drop_cnt_o[c*8 +: 8] = r_drop_cnt;
`else
    // This build has no drop statistics.
`endif
  end

endmodule
